aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
- Sequences one AES block operation over the iterative round datapath and the round-key store.
- Requests each round key through a req/ack handshake, then pulses the datapath load, per-round enable, final-round flag and done strobe.
- Supports encrypt and decrypt; decrypt walks round keys in reverse order.
- Sits between the top-level command interface and the round/key-expansion datapath.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14.
- CW, 4, width of round counter and key index; must satisfy 2^CW > NR.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operation request; accepted only when ready=1.
- decrypt  in  1  mode; sampled on the start-accepting edge (0 = encrypt, 1 = decrypt).
- abort  in  1  synchronous cancel of the current operation.
- key_ack  in  1  key store has round_sel key valid this cycle.
- ready  out  1  high in IDLE only.
- busy  out  1  equals ~ready.
- inv  out  1  registered mode of the current operation.
- key_req  out  1  round-key request; held until acked.
- round_sel  out  CW  round-key index requested/applied.
- load_state  out  1  one-cycle pulse: datapath loads input XOR key 0 (enc) or key NR (dec).
- round_en  out  1  one-cycle pulse: datapath executes one round.
- final_round  out  1  high with round_en on the last round (datapath skips (Inv)MixColumns).
- round  out  CW  current round number, 0..NR.
- done  out  1  one-cycle pulse: result valid; datapath output register enable.

Behaviour:
- FSM states: IDLE, KEY0, INIT, KEYR, ROUND, DONE. All outputs are Moore-decoded from state and registered counters; no input-to-output combinational paths.
- Reset (async): state=IDLE, round=0, inv=0. Outputs: ready=1; busy, key_req, load_state, round_en, final_round, done all 0; round_sel=0.
- IDLE: on start=1 → KEY0, round←0, inv←decrypt. start while not IDLE is ignored, with no queuing.
- KEY0: key_req=1. key_ack=1 → INIT; else stay.
- INIT: load_state=1 → KEYR, round←1.
- KEYR: key_req=1. key_ack=1 → ROUND; else stay, with round_sel held stable.
- ROUND: round_en=1; final_round=(round==NR).
  - round<NR → KEYR, round←round+1.
  - round==NR → DONE.
- DONE: done=1 → IDLE. round is held at NR until the next accepted start.
- round_sel = round when inv=0; round_sel = NR−round when inv=1. Computed in CW bits, with no wrap because round≤NR.
- key_ack is ignored outside KEY0/KEYR.
- Latency with key_ack tied high:
  - start accepted at edge E → KEY0 in cycle E+1, INIT in E+2.
  - Each round takes 2 cycles (KEYR, ROUND).
  - done is asserted in cycle E+3+2·NR (cycle 23 for NR=10). ready=1 in E+4+2·NR.
- Each cycle of key_ack=0 in KEY0/KEYR adds exactly one cycle of latency.
- abort=1 in any non-IDLE state → IDLE next edge; no done, round_en or load_state after that edge. abort has priority over key_ack and over the DONE→IDLE transition (done still shows this cycle if already in DONE). abort in IDLE has no effect.
- Back-to-back: start is sampled only in IDLE, so the minimum spacing between accepted starts is 2·NR+4 cycles.
- Reset mid-operation: immediate return to IDLE, reset values, no partial done.

Test Plan:
- Encrypt, NR=10, key_ack=1, start at edge 0 → load_state in cycle 2 with round_sel=0; round_en at cycles 4,6,…,22 with round_sel=1..10; final_round only at cycle 22; done at cycle 23; ready=1 at cycle 24.
- Decrypt, same timing → round_sel=10 at load_state, then 9,8,…,0 on successive round_en; inv=1 throughout; decrypt toggled mid-operation has no effect.
- Key stall: key_ack low 3 cycles in KEY0 and 5 cycles in KEYR of round 4 → key_req held, round_sel stable, done delayed by exactly 8 cycles (cycle 31).
- Abort: abort=1 during ROUND of round 6 → IDLE next edge, ready=1; no done; next start completes normally from round 0.
- Reset asserted asynchronously in KEYR of round 3 → outputs at reset values immediately; a following start gives the standard 23-cycle done.
- start pulsed every cycle → operations accepted only at edges where ready=1 (every 24 cycles for NR=10); parameter sweep NR=12/14 → done at cycle 27/31.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control FSM that walks one AES block through the iterative round datapath.
// Requests each round key over req/ack, then strobes load, per-round enable, final-round flag and done.
module aes_round_sequencer #(
    parameter int unsigned NR = 10,
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          decrypt,
    input  logic          abort,
    input  logic          key_ack,
    output logic          ready,
    output logic          busy,
    output logic          inv,
    output logic          key_req,
    output logic [CW-1:0] round_sel,
    output logic          load_state,
    output logic          round_en,
    output logic          final_round,
    output logic [CW-1:0] round,
    output logic          done
);

    localparam logic [CW-1:0] LAST_ROUND = CW'(NR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY0,
        S_INIT,
        S_KEYR,
        S_ROUND,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] round_q, round_d;
    logic          inv_q, inv_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state: key fetch precedes every load/round step; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KEY0;
                    round_d = '0;
                    inv_d   = decrypt;
                end
            end
            S_KEY0: begin
                if (key_ack) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_KEYR;
                round_d = CW'(1);
            end
            S_KEYR: begin
                if (key_ack) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_KEYR;
                    round_d = round_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            round_d = round_q;
        end
    end

    // Moore decode: outputs depend only on state and registered counters.
    always_comb begin
        ready       = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        inv         = inv_q;
        key_req     = (state_q == S_KEY0) || (state_q == S_KEYR);
        load_state  = (state_q == S_INIT);
        round_en    = (state_q == S_ROUND);
        final_round = (state_q == S_ROUND) && (round_q == LAST_ROUND);
        done        = (state_q == S_DONE);
        round       = round_q;
        round_sel   = inv_q ? (LAST_ROUND - round_q) : round_q;
    end

endmodule
